// File: rtl/barret_pkg.sv
// Purpose: shared constants, pipeline-stage type and helper for the 1361 Barrett reducer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package barret_pkg;

    localparam int MOD_Q    = 1361;
    localparam int MU       = 3081;                // floor(2^22 / 1361)
    localparam int SHIFT_K  = 11;
    localparam int DIN_W    = 21;
    localparam int DOUT_W   = 11;
    localparam int ID_MAX_W = 4;                   // enough for up to 16 requesters
    localparam int QV_W     = DIN_W - SHIFT_K;     // 10-bit coarse quotient input
    localparam int QH_W     = 22;                  // full qv*MU product, never truncated

    // One pipeline stage: valid bit, payload and issuing requester.
    typedef struct packed {
        logic                valid;
        logic [DIN_W-1:0]    data;
        logic [ID_MAX_W-1:0] id;
    } stage_t;

    // One conditional subtraction of the modulus.
    function automatic logic [DIN_W-1:0] cond_sub(input logic [DIN_W-1:0] r);
        return (r >= DIN_W'(MOD_Q)) ? (r - DIN_W'(MOD_Q)) : r;
    endfunction

endpackage

// File: rtl/barret_pipe_1361.sv
// Purpose: 3-stage pipelined Barrett reduction of a 21-bit operand modulo 1361.
// Latency: 3 cycles from in_valid capture to out_valid; 1 result per cycle.
// Backpressure: global stall - every stage holds while adv=0, bubbles are kept.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   adv                 advance enable for all stages
//   in_valid/data/id    operand entering S1 (captured when adv=1)
//   out_valid/data/id   S3 result: residue 0..1360 and issuing requester index
module barret_pipe_1361
    import barret_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  logic                in_valid,
    input  logic [DIN_W-1:0]    in_data,
    input  logic [ID_MAX_W-1:0] in_id,
    output logic                out_valid,
    output logic [DOUT_W-1:0]   out_data,
    output logic [ID_MAX_W-1:0] out_id
);

    stage_t s1;
    stage_t s2;
    stage_t s3;
    logic [DOUT_W-1:0] s2_t;       // quotient estimate carried alongside S2

    // S1 -> S2: quotient estimate t = ((a >> 11) * 3081) >> 11
    logic [QV_W-1:0]   qv;
    logic [QH_W-1:0]   qh;
    logic [DOUT_W-1:0] t_nxt;

    // S2 -> S3: r = a - t*1361, then at most two corrections
    logic [DIN_W-1:0] tq;
    logic [DIN_W-1:0] r0;
    logic [DIN_W-1:0] r1;
    logic [DIN_W-1:0] r2;

    always_comb begin
        qv    = QV_W'(s1.data >> SHIFT_K);
        qh    = QH_W'(qv) * QH_W'(MU);
        t_nxt = DOUT_W'(qh >> SHIFT_K);
    end

    // t never exceeds floor(a/1361), so r0 cannot underflow, and the
    // estimate error is below 3*1361, so two corrections always suffice.
    always_comb begin
        tq = DIN_W'(s2_t) * DIN_W'(MOD_Q);
        r0 = s2.data - tq;
        r1 = cond_sub(r0);
        r2 = cond_sub(r1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            s3   <= '0;
            s2_t <= '0;
        end else if (adv) begin
            s1   <= '{valid: in_valid, data: in_data, id: in_id};
            s2   <= '{valid: s1.valid, data: s1.data, id: s1.id};
            s2_t <= t_nxt;
            s3   <= '{valid: s2.valid, data: r2, id: s2.id};
        end
    end

    assign out_valid = s3.valid;
    assign out_data  = s3.data[DOUT_W-1:0];
    assign out_id    = s3.id;

    // Residue fits in DOUT_W bits; the upper payload bits of S3 are always zero.
    logic unused_s3_hi;
    assign unused_s3_hi = ^s3.data[DIN_W-1:DOUT_W];

endmodule

// File: rtl/barret_arb_1361.sv
// Purpose: round-robin arbiter sharing one pipelined mod-1361 Barrett reducer among NUM_REQ requesters.
// Latency: 3 cycles from request handshake to rsp_valid; full throughput of 1 result/cycle.
// Backpressure: rsp_valid && !rsp_ready stalls the whole pipe and drops every req_ready.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/ready/data      per-requester operand channels; req i uses req_data[21*i +: 21]
//   rsp_valid/ready/data/id   single result channel: residue 0..1360 and issuing requester
//   stat_ops, stat_stall      saturating counters, present only with BARRET_ARB_STATS_EN defined
module barret_arb_1361
    import barret_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*DIN_W-1:0] req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DOUT_W-1:0]        rsp_data,
`ifdef BARRET_ARB_STATS_EN
    output logic [31:0]              stat_ops,
    output logic [31:0]              stat_stall,
`endif
    output logic [ID_W-1:0]          rsp_id
);

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     cand;
    logic                found;
    logic                adv;
    logic                accept_ok;
    logic                hs;
    logic                pipe_valid;
    logic [DOUT_W-1:0]   pipe_data;
    logic [ID_MAX_W-1:0] pipe_id;

    // Global stall: only a held result at the output blocks progress.
    assign adv       = !(pipe_valid && !rsp_ready);
    // No grants while reset is asserted, so req_ready reads 0 during reset.
    assign accept_ok = adv && !rst;

    // First valid requester searching upward from ptr with wrap.
    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = ID_W'((int'(ptr) + j) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign hs        = found && accept_ok;
    assign req_ready = hs ? (NUM_REQ'(1) << grant) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
        end
    end

    // A bubble is inserted whenever nothing is granted, so in_valid is hs.
    barret_pipe_1361 u_pipe (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .in_valid  (hs),
        .in_data   (req_data[int'(grant)*DIN_W +: DIN_W]),
        .in_id     (ID_MAX_W'(grant)),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .out_id    (pipe_id)
    );

    assign rsp_valid = pipe_valid;
    assign rsp_data  = pipe_data;
    assign rsp_id    = pipe_id[ID_W-1:0];

    // The carried id is sized for the largest configuration.
    logic unused_id;
    assign unused_id = ^pipe_id;

`ifdef BARRET_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (pipe_valid && rsp_ready && (stat_ops != '1)) begin
                stat_ops <= stat_ops + 1'b1;
            end
            if (pipe_valid && !rsp_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif

endmodule
